// File: rtl/b1_dec_pkg.sv
// b1_dec_pkg: shared types and helpers for the b1 line-symbol decoder.
// Symbol layout is {pd, pe, pf, pg} with pd in bit 3.
package b1_dec_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam int PD = 3;
    localparam int PE = 2;
    localparam int PF = 1;
    localparam int PG = 0;

    // A code word is legal when pd and pg differ and pe/pf are never both set.
    function automatic logic sym_legal(input logic [3:0] sym);
        return (sym[PD] ^ sym[PG]) & ~(sym[PE] & sym[PF]);
    endfunction

    // Recover {c, ne, ab}; ab only carries information when a equals b (ne = 0).
    function automatic logic [2:0] sym_decode(input logic [3:0] sym);
        logic ne;
        ne = sym[PE];
        return {sym[PD], ne, (ne ? 1'b0 : (sym[PF] ^ sym[PD]))};
    endfunction

endpackage

// File: rtl/b1_dec_fifo.sv
// b1_dec_fifo: generic 2-entry valid/ready FIFO. Ready and valid come straight
// from the occupancy register, so there is no combinational in-to-out path.
module b1_dec_fifo #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_cnt;
    logic             w_push;
    logic             w_pop;

    assign in_ready  = (r_cnt != 2'd2);
    assign out_valid = (r_cnt != 2'd0);
    assign out_data  = r_mem[r_rd_ptr];
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    // Storage, pointers and occupancy; simultaneous push/pop keeps occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_cnt    <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= in_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/b1_dec.sv
// b1_dec: b1 symbol checker, lock/hunt framing FSM and decoded-field output.
// Optional feature: define B1_DEC_ERRCNT_EN to build the saturating error
// counter and its clr_err input; otherwise err_count is tied to zero.
module b1_dec
    import b1_dec_pkg::*;
#(
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 2,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_sym,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_data,
    output logic             locked,
    output logic             sym_err,
    input  logic             clr_err,
    output logic [ERR_W-1:0] err_count
);

    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int BAD_W  = $clog2(UNLOCK_CNT + 1);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_CNT - 1);
    localparam logic [BAD_W-1:0]  BAD_LAST  = BAD_W'(UNLOCK_CNT - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [GOOD_W-1:0] r_good_cnt;
    logic [GOOD_W-1:0] w_good_nxt;
    logic [BAD_W-1:0]  r_bad_cnt;
    logic [BAD_W-1:0]  w_bad_nxt;
    logic              r_sym_err;
    logic              w_fifo_in_ready;
    logic              w_accept;
    logic              w_legal;
    logic              w_push;
    logic              w_err_inc;

    assign in_ready  = w_fifo_in_ready;
    assign w_accept  = in_valid & w_fifo_in_ready;
    assign w_legal   = sym_legal(in_sym);
    assign w_push    = w_accept & w_legal & (r_state == LOCKED);
    assign w_err_inc = w_accept & ~w_legal & (r_state == LOCKED);
    assign locked    = (r_state == LOCKED);
    assign sym_err   = r_sym_err;

    // Framing state and run-length counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= HUNT;
            r_good_cnt <= '0;
            r_bad_cnt  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_good_cnt <= w_good_nxt;
            r_bad_cnt  <= w_bad_nxt;
        end
    end

    // Next-state: count legal runs in HUNT, illegal runs in LOCKED.
    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good_cnt;
        w_bad_nxt   = r_bad_cnt;
        if (w_accept) begin
            case (r_state)
                HUNT: begin
                    if (!w_legal) begin
                        w_good_nxt = '0;
                    end else if (r_good_cnt == GOOD_LAST) begin
                        w_state_nxt = LOCKED;
                        w_good_nxt  = '0;
                    end else begin
                        w_good_nxt = r_good_cnt + GOOD_W'(1);
                    end
                end
                LOCKED: begin
                    if (w_legal) begin
                        w_bad_nxt = '0;
                    end else if (r_bad_cnt == BAD_LAST) begin
                        w_state_nxt = HUNT;
                        w_bad_nxt   = '0;
                    end else begin
                        w_bad_nxt = r_bad_cnt + BAD_W'(1);
                    end
                end
                default: w_state_nxt = HUNT;
            endcase
        end
    end

    // One-cycle error pulse for any illegal accepted symbol, either state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sym_err <= 1'b0;
        end else begin
            r_sym_err <= w_accept & ~w_legal;
        end
    end

`ifdef B1_DEC_ERRCNT_EN
    logic [ERR_W-1:0] r_err_count;

    // Saturating count of illegal symbols seen while locked; clear has priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_count <= '0;
        end else if (clr_err) begin
            r_err_count <= '0;
        end else if (w_err_inc && (r_err_count != {ERR_W{1'b1}})) begin
            r_err_count <= r_err_count + ERR_W'(1);
        end
    end

    assign err_count = r_err_count;
`else
    logic w_unused_err;
    assign w_unused_err = clr_err ^ w_err_inc;
    assign err_count    = '0;
`endif

    b1_dec_fifo #(
        .WIDTH(3)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (w_push),
        .in_ready (w_fifo_in_ready),
        .in_data  (sym_decode(in_sym)),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
    );

endmodule

// File: tb/tb_b1_dec.sv
// tb_b1_dec: directed-vector bench for b1_dec (LOCK_CNT=4, UNLOCK_CNT=2,
// ERR_W=2). Expected error counts follow whether B1_DEC_ERRCNT_EN is defined.
module tb_b1_dec;

`ifdef B1_DEC_ERRCNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_sym;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_data;
    logic       locked;
    logic       sym_err;
    logic       clr_err;
    logic [1:0] err_count;

    int n_checks;
    int n_fails;

    b1_dec #(
        .LOCK_CNT  (4),
        .UNLOCK_CNT(2),
        .ERR_W     (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_sym   (in_sym),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .locked   (locked),
        .sym_err  (sym_err),
        .clr_err  (clr_err),
        .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] sym);
        in_valid = 1'b1;
        in_sym   = sym;
        tick();
        in_valid = 1'b0;
        in_sym   = 4'b0000;
    endtask

    function automatic logic [7:0] exp_err(input int n);
        return ERR_EN ? 8'(n) : 8'd0;
    endfunction

    initial begin
        n_checks  = 0;
        n_fails   = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sym    = 4'b0000;
        out_ready = 1'b1;
        clr_err   = 1'b0;
        tick();
        tick();
        check_val("rst_in_ready", 8'(in_ready), 8'd1);
        check_val("rst_out_valid", 8'(out_valid), 8'd0);
        check_val("rst_out_data", 8'(out_data), 8'd0);
        check_val("rst_locked", 8'(locked), 8'd0);
        check_val("rst_sym_err", 8'(sym_err), 8'd0);
        check_val("rst_err_count", 8'(err_count), 8'd0);
        rst_n = 1'b1;
        tick();

        // Lock on four legal symbols; none of them reaches the output.
        for (int i = 0; i < 4; i++) begin
            send(4'b1010);
            check_val("hunt_no_out", 8'(out_valid), 8'd0);
            check_val("hunt_locked", 8'(locked), (i == 3) ? 8'd1 : 8'd0);
        end
        send(4'b1010);
        check_val("s1_valid", 8'(out_valid), 8'd1);
        check_val("s1_data", 8'(out_data), 8'b100);
        tick();
        check_val("s1_drained", 8'(out_valid), 8'd0);

        // Back-to-back legal symbols, one output per cycle.
        send(4'b0011);
        check_val("s2_d0", 8'(out_data), 8'b001);
        check_val("s2_v0", 8'(out_valid), 8'd1);
        send(4'b0001);
        check_val("s2_d1", 8'(out_data), 8'b000);
        send(4'b1100);
        check_val("s2_d2", 8'(out_data), 8'b110);
        tick();
        check_val("s2_drained", 8'(out_valid), 8'd0);

        // Two illegal symbols: both flagged, counted, dropped; lock lost.
        send(4'b1001);
        check_val("s3_err0", 8'(sym_err), 8'd1);
        check_val("s3_cnt0", 8'(err_count), exp_err(1));
        check_val("s3_lock0", 8'(locked), 8'd1);
        check_val("s3_out0", 8'(out_valid), 8'd0);
        send(4'b1110);
        check_val("s3_err1", 8'(sym_err), 8'd1);
        check_val("s3_cnt1", 8'(err_count), exp_err(2));
        check_val("s3_lock1", 8'(locked), 8'd0);
        check_val("s3_out1", 8'(out_valid), 8'd0);
        tick();
        check_val("s3_err_pulse", 8'(sym_err), 8'd0);

        // Relock, then backpressure: two entries buffered, third held off.
        for (int i = 0; i < 4; i++) send(4'b1010);
        check_val("s4_relock", 8'(locked), 8'd1);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sym    = 4'b0011;
        tick();
        in_sym = 4'b0001;
        tick();
        check_val("s4_full_rdy", 8'(in_ready), 8'd0);
        check_val("s4_full_data", 8'(out_data), 8'b001);
        in_sym = 4'b1100;
        tick();
        check_val("s4_hold_rdy", 8'(in_ready), 8'd0);
        check_val("s4_hold_data", 8'(out_data), 8'b001);
        check_val("s4_hold_valid", 8'(out_valid), 8'd1);
        out_ready = 1'b1;
        tick();
        check_val("s4_drain1", 8'(out_data), 8'b000);
        check_val("s4_drain1_rdy", 8'(in_ready), 8'd1);
        tick();
        in_valid = 1'b0;
        check_val("s4_third", 8'(out_data), 8'b110);
        check_val("s4_third_v", 8'(out_valid), 8'd1);
        tick();
        check_val("s4_empty", 8'(out_valid), 8'd0);

        // Saturation with a 2-bit counter, then clear beating an increment.
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check_val("s5_clr", 8'(err_count), 8'd0);
        for (int i = 0; i < 6; i++) begin
            send(4'b1001);
            if (i == 2) check_val("s5_cnt3", 8'(err_count), exp_err(3));
            send(4'b1010);
        end
        check_val("s5_sat", 8'(err_count), exp_err(3));
        check_val("s5_lock", 8'(locked), 8'd1);
        clr_err = 1'b1;
        send(4'b1001);
        clr_err = 1'b0;
        check_val("s5_clr_wins", 8'(err_count), 8'd0);
        check_val("s5_clr_err", 8'(sym_err), 8'd1);

        // Reset mid-stream with a full buffer while locked.
        out_ready = 1'b0;
        send(4'b0011);
        send(4'b0001);
        check_val("s6_full_v", 8'(out_valid), 8'd1);
        check_val("s6_full_rdy", 8'(in_ready), 8'd0);
        check_val("s6_locked", 8'(locked), 8'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("s6_rst_valid", 8'(out_valid), 8'd0);
        check_val("s6_rst_locked", 8'(locked), 8'd0);
        check_val("s6_rst_rdy", 8'(in_ready), 8'd1);
        check_val("s6_rst_data", 8'(out_data), 8'd0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/b1_dec.md
# b1_dec

Receive-side decoder for the 4-bit b1 line symbol {pd, pe, pf, pg}, the symbol produced by the b1 encoder from source bits (a, b, c). Accepts symbols over a valid/ready stream and checks each for code-word legality. Runs a lock/hunt framing state machine and delivers decoded fields through a 2-entry output buffer. Sits between the symbol link and the consumer of the recovered (a, b, c) information.

## Interface
- LOCK_CNT, 4, consecutive legal symbols needed in HUNT to enter LOCKED (≥1)
- UNLOCK_CNT, 2, consecutive illegal symbols needed in LOCKED to return to HUNT (≥1)
- ERR_W, 8, width of the saturating error counter
- clk  in  1  rising-edge clock, the only clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  symbol present
- in_ready  out  1  block can accept a symbol
- in_sym  in  4  bit3 = pd, bit2 = pe, bit1 = pf, bit0 = pg
- out_valid  out  1  decoded entry present
- out_ready  in  1  consumer takes the entry
- out_data  out  3  {c, ne, ab}: c = pd; ne = pe (a≠b); ab = pf^pd when ne = 0, else 0
- locked  out  1  framing state is LOCKED
- sym_err  out  1  one-cycle pulse, registered, for an illegal accepted symbol
- clr_err  in  1  synchronous clear of err_count
- err_count  out  ERR_W  illegal symbols accepted while LOCKED, saturating

## Operation
- Accept a symbol when in_valid & in_ready. Without acceptance, in_sym is ignored.
- A symbol is legal iff (pd ^ pg) = 1 and !(pe & pf). It is illegal otherwise.
- FSM state HUNT, with good_cnt:
  - A legal symbol increments good_cnt.
  - When good_cnt reaches LOCK_CNT, go to LOCKED and clear good_cnt.
  - An illegal symbol clears good_cnt.
  - No symbol is pushed to the buffer in HUNT, including the symbol that completes lock.
- FSM state LOCKED, with bad_cnt:
  - A legal symbol is decoded and pushed, and bad_cnt is cleared.
  - An illegal symbol is dropped, increments bad_cnt and increments err_count.
  - When bad_cnt reaches UNLOCK_CNT, go to HUNT and clear bad_cnt.
- sym_err pulses for every illegal accepted symbol, in both states.
- err_count saturates at 2^ERR_W−1. If clr_err and an increment occur in the same cycle, clr_err wins and the result is 0.
- Output buffer: 2-entry FIFO.
  - in_ready = !full. A symbol is never accepted when the FIFO is full, even if out_ready is high.
  - Push and pop in the same cycle: occupancy is unchanged and order is preserved.
  - out_valid = !empty. out_data holds stable while out_valid & !out_ready.
- Reset values: HUNT state, counters 0, FIFO empty, in_ready = 1, out_valid = 0, out_data = 0, locked = 0, sym_err = 0, err_count = 0.
- Reset asserted mid-stream discards the FIFO contents and all lock progress immediately.

## Timing
- Symbol accepted at edge N: its out_valid is high after edge N (1-cycle latency). sym_err is high for the cycle after edge N.
- locked rises after the edge that accepts the LOCK_CNT-th consecutive legal symbol. It falls after the edge that accepts the UNLOCK_CNT-th consecutive illegal symbol.
- Throughput: 1 symbol/cycle while out_ready is held high.
- All outputs are registered, or are a function of registered state only (in_ready, out_valid). There are no combinational in→out paths.

## Configuration
- B1_DEC_ERRCNT_EN defined: the error counter and clr_err logic are present as described above.
- B1_DEC_ERRCNT_EN undefined: no counter is built. err_count is tied to 0 and clr_err is ignored. sym_err and the FSM are unchanged.

## Structure
- Package b1_dec_pkg holds:
  - the state enum {HUNT, LOCKED};
  - symbol bit-index constants (PD = 3, PE = 2, PF = 1, PG = 0);
  - a sym_legal function;
  - a decode function returning {c, ne, ab}.
- Sub-module b1_dec_fifo: a generic 2-entry valid/ready FIFO, width 3. It holds all buffering. The FSM and the checker stay in b1_dec.

## Test plan
- Reset, then 4× 4'b1010 with out_ready = 1: locked rises after the 4th symbol and there is no out_valid. Next, 4'b1010 gives out_data = 3'b100 one cycle later.
- Locked, send 4'b0011, 4'b0001, 4'b1100: out_data = 3'b001, 3'b000, 3'b110 in order, one per cycle.
- Locked, send 4'b1001 then 4'b1110: sym_err pulses twice and err_count = 2. locked falls after the second symbol and neither symbol is output.
- Locked, out_ready = 0, present 3 legal symbols: the first two are buffered and in_ready = 0 on the third. Raise out_ready: entries drain in order and the third is accepted afterwards.
- ERR_W = 2, LOCKED, alternate an illegal symbol and 4'b1010 six times: err_count saturates at 3. clr_err coincident with the next illegal symbol gives err_count = 0.
- Assert rst_n low while 2 entries are buffered and locked = 1: out_valid = 0, locked = 0, in_ready = 1 immediately. Build without B1_DEC_ERRCNT_EN: err_count stays 0 under the scenario 3 stimulus.
